// File: rtl/sensor_request_latch.sv
// Sensor/button front end: 2-flop sync, per-lane debounce FSM, sticky requests cleared by served.
// Optional per-lane starvation age counters enabled by defining SENSOR_REQ_AGE_EN.
module sensor_request_latch #(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 19,
  parameter int AGE_MAX    = 30
) (
  input  logic       clk,
  input  logic       in_rst,
  input  logic [3:0] in_btn,
  input  logic [3:0] in_served,
  input  logic       in_tick,
  output logic [3:0] ou_NSEW,
  output logic       ou_any,
  output logic [3:0] ou_starve
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_PRESSED = 2'd2;
  localparam logic [1:0] ST_REL     = 2'd3;

  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

  function automatic logic [DEB_W-1:0] deb_inc(input logic [DEB_W-1:0] c);
    return (c >= DEB_MAX) ? c : c + DEB_ONE;
  endfunction

  logic [3:0]            s1, s2;
  logic [3:0][1:0]       st, st_nxt;
  logic [3:0][DEB_W-1:0] cnt, cnt_nxt;
  logic [3:0]            accept;
  logic [3:0]            r, r_nxt;

  // ---- stage: two-flop synchroniser
  always_ff @(posedge clk) begin
    if (in_rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_btn;
      s2 <= s1;
    end
  end

  // ---- stage: debounce FSM; accept fires only on ARM -> PRESSED
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      st_nxt[i]  = st[i];
      cnt_nxt[i] = cnt[i];
      accept[i]  = 1'b0;
      case (st[i])
        ST_IDLE: begin
          if (s2[i]) begin
            st_nxt[i]  = ST_ARM;
            cnt_nxt[i] = DEB_ONE;
          end
        end
        ST_ARM: begin
          if (!s2[i]) begin
            st_nxt[i]  = ST_IDLE;
            cnt_nxt[i] = '0;
          end else if (cnt[i] >= DEB_LAST) begin
            st_nxt[i]  = ST_PRESSED;
            cnt_nxt[i] = '0;
            accept[i]  = 1'b1;
          end else begin
            cnt_nxt[i] = deb_inc(cnt[i]);
          end
        end
        ST_PRESSED: begin
          if (!s2[i]) begin
            st_nxt[i]  = ST_REL;
            cnt_nxt[i] = DEB_ONE;
          end
        end
        default: begin
          if (s2[i]) begin
            st_nxt[i]  = ST_PRESSED;
            cnt_nxt[i] = '0;
          end else if (cnt[i] >= DEB_LAST) begin
            st_nxt[i]  = ST_IDLE;
            cnt_nxt[i] = '0;
          end else begin
            cnt_nxt[i] = deb_inc(cnt[i]);
          end
        end
      endcase
    end
  end

  // Serve wins over a simultaneous accept.
  assign r_nxt = ~in_served & (r | accept);

  // ---- stage: FSM state and request register
  always_ff @(posedge clk) begin
    if (in_rst) begin
      st     <= '0;
      cnt    <= '0;
      r      <= '0;
      ou_any <= 1'b0;
    end else begin
      st     <= st_nxt;
      cnt    <= cnt_nxt;
      r      <= r_nxt;
      ou_any <= |r_nxt;
    end
  end

  assign ou_NSEW = r;

`ifdef SENSOR_REQ_AGE_EN
  localparam logic [7:0] AGE_LIM = 8'(AGE_MAX);

  function automatic logic [7:0] age_inc(input logic [7:0] a);
    return (a >= AGE_LIM) ? a : a + 8'd1;
  endfunction

  logic [3:0][7:0] age, age_nxt;
  logic [3:0]      starve_nxt;

  // A tick on the set edge is ignored because r is still 0 in that cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      age_nxt[i]    = '0;
      starve_nxt[i] = 1'b0;
      if (r_nxt[i]) begin
        age_nxt[i]    = (r[i] && in_tick) ? age_inc(age[i]) : age[i];
        starve_nxt[i] = (age_nxt[i] == AGE_LIM);
      end
    end
  end

  // ---- stage: age counters and starvation flags
  always_ff @(posedge clk) begin
    if (in_rst) begin
      age       <= '0;
      ou_starve <= '0;
    end else begin
      age       <= age_nxt;
      ou_starve <= starve_nxt;
    end
  end
`else
  logic unused_age;
  assign unused_age = in_tick ^ (AGE_MAX == 0);
  assign ou_starve  = 4'b0000;
`endif

endmodule
